// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared op codes, op-class decode helpers, FSM state encoding and latency defaults
// for the HI/LO multiply-divide issue controller.
package mdu_issue_ctrl_pkg;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;
    localparam int CNT_W_DEF   = 4;

    // Code 0 is reserved for "no MDU op" on the mdu_op bus.
    localparam logic [4:0] OP_MULT  = 5'h10;
    localparam logic [4:0] OP_MULTU = 5'h11;
    localparam logic [4:0] OP_DIV   = 5'h12;
    localparam logic [4:0] OP_DIVU  = 5'h13;
    localparam logic [4:0] OP_MTHI  = 5'h14;
    localparam logic [4:0] OP_MTLO  = 5'h15;
    localparam logic [4:0] OP_MFHI  = 5'h16;
    localparam logic [4:0] OP_MFLO  = 5'h17;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2
    } md_state_t;

    function automatic logic is_mul(input logic [4:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_start(input logic [4:0] op);
        return is_mul(op) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_mt(input logic [4:0] op);
        return (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

    function automatic logic is_mf(input logic [4:0] op);
        return (op == OP_MFHI) || (op == OP_MFLO);
    endfunction

    function automatic logic is_md(input logic [4:0] op);
        return is_start(op) || is_mt(op) || is_mf(op);
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl_busy_model.sv
// Cycle-exact busy model of the MDU: a down-counter loaded on start and a MUL/DIV/IDLE FSM.
// A low enable freezes both, mirroring the MDU pausing its own count.
module md_busy_model
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       is_mul,
    input  logic       enable,
    output logic       busy_m,
    output logic [1:0] state
);

    logic [CNT_W-1:0] cnt;
    md_state_t        state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            state_q <= MD_IDLE;
        end else if (enable) begin
            if (start) begin
                cnt     <= is_mul ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
                state_q <= is_mul ? MD_MUL : MD_DIV;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
                // Leave MUL/DIV on the same edge the count reaches zero.
                if (cnt == CNT_W'(1))
                    state_q <= MD_IDLE;
            end
        end
    end

    assign busy_m = (cnt != '0);
    assign state  = state_q;

endmodule

// File: rtl/mdu_issue_ctrl.sv
// MDU issue/stall controller: drives MDU start/enable/op from E, stalls D-stage MDU ops
// while the busy model is active. Optional busy cross-check under macro MDU_CHECK_EN.
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] op_d,
    input  logic [4:0] op_e,
    input  logic       valid_e,
    input  logic       exc_req,
    input  logic       mdu_busy,
    output logic       mdu_start,
    output logic       mdu_enable,
    output logic [4:0] mdu_op,
    output logic       stall_d,
    output logic [1:0] md_state,
    output logic       mismatch
);

    logic busy_m;

    // Exceptions pause the MDU rather than cancel it; a start in the same cycle is dropped.
    assign mdu_enable = !exc_req;
    assign mdu_op     = valid_e ? op_e : 5'd0;
    assign mdu_start  = valid_e && is_start(op_e) && !exc_req;
    assign stall_d    = is_md(op_d) && (busy_m || mdu_start);

    md_busy_model #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_busy_model (
        .clk    (clk),
        .reset  (reset),
        .start  (mdu_start),
        .is_mul (is_mul(op_e)),
        .enable (mdu_enable),
        .busy_m (busy_m),
        .state  (md_state)
    );

`ifdef MDU_CHECK_EN
    // Sticky: any cycle where the model and the real MDU disagree is latched until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mismatch <= 1'b0;
        end else if (busy_m != mdu_busy) begin
            mismatch <= 1'b1;
`ifndef SYNTHESIS
            $display("%0t mdu_issue_ctrl: busy mismatch busy_m=%0b mdu_busy=%0b state=%0d op=%0h",
                     $time, busy_m, mdu_busy, md_state, mdu_op);
`endif
        end
    end
`else
    logic unused_mdu_busy;
    assign unused_mdu_busy = mdu_busy;
    assign mismatch        = 1'b0;
`endif

endmodule
